// File: rtl/hazard_pkg.sv
// Shared hazard-unit types: stage tracking record, bubble
// constants and the saturating Tnew step.
package hazard_pkg;

  localparam int HZ_AW = 5;
  localparam int HZ_TW = 2;

  localparam logic [HZ_TW-1:0] TUSE_NONE = '1;
  localparam logic [HZ_AW-1:0] BUBBLE_A  = '0;
  localparam logic [HZ_TW-1:0] BUBBLE_T  = '0;

  typedef struct packed {
    logic [HZ_AW-1:0] a3;
    logic [HZ_TW-1:0] tnew;
  } stage_t;

  localparam stage_t BUBBLE = '{a3: BUBBLE_A, tnew: BUBBLE_T};

  function automatic logic [HZ_TW-1:0] sat_dec(
    input logic [HZ_TW-1:0] t
  );
    return (t == '0) ? '0 : t - HZ_TW'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div occupancy counter: loads on start, counts down
// to zero, busy while nonzero.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ?
                        DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A start while busy simply reloads.
  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: tracks E/M/W producers, derives D-stage stall
// and D/E operand forwarding, plus mult/div busy stalling.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = HZ_AW,
  parameter int TW          = HZ_TW,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] D_A1,
  input  logic [AW-1:0] D_A2,
  input  logic [TW-1:0] D_Tuse1,
  input  logic [TW-1:0] D_Tuse2,
  input  logic [AW-1:0] D_A3,
  input  logic [TW-1:0] D_Tnew,
  input  logic          D_MD,
  input  logic [DW-1:0] D_RD1,
  input  logic [DW-1:0] D_RD2,
  input  logic [DW-1:0] E_RD1,
  input  logic [DW-1:0] E_RD2,
  input  logic          E_start,
  input  logic          E_is_div,
  input  logic [DW-1:0] Data_E,
  input  logic [DW-1:0] Data_M,
  input  logic [DW-1:0] Data_W,
  output logic          stall,
  output logic          md_busy,
  output logic [DW-1:0] RD1_D_final,
  output logic [DW-1:0] RD2_D_final,
  output logic [DW-1:0] RD1_E_final,
  output logic [DW-1:0] RD2_E_final
);

  stage_t        e_q, e_d, m_q, m_d;
  logic [AW-1:0] e_a1_q, e_a1_d, e_a2_q, e_a2_d;
  logic [AW-1:0] w_a3_q, w_a3_d;
  logic          e_u1_q, e_u1_d, e_u2_q, e_u2_d;
  logic          stall1, stall2, md_stall;

  function automatic logic hit(
    input logic [AW-1:0] a,
    input logic [AW-1:0] dst
  );
    return (a != '0) && (a == dst);
  endfunction

  // Younger producer (E) decides whenever it matches.
  function automatic logic src_stall(
    input logic [AW-1:0] a,
    input logic [TW-1:0] tuse,
    input stage_t        e,
    input stage_t        m
  );
    if (tuse == TUSE_NONE) return 1'b0;
    if (hit(a, e.a3))      return e.tnew > tuse;
    return hit(a, m.a3) && (m.tnew > tuse);
  endfunction

  function automatic logic [DW-1:0] fwd(
    input logic          he,
    input logic          hm,
    input logic          hw,
    input logic [DW-1:0] de,
    input logic [DW-1:0] dm,
    input logic [DW-1:0] dw,
    input logic [DW-1:0] dr
  );
    if (he) return de;
    if (hm) return dm;
    if (hw) return dw;
    return dr;
  endfunction

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (E_start),
    .is_div (E_is_div),
    .busy   (md_busy)
  );

  assign stall1   = src_stall(D_A1, D_Tuse1, e_q, m_q);
  assign stall2   = src_stall(D_A2, D_Tuse2, e_q, m_q);
  assign md_stall = D_MD && (md_busy || E_start);
  assign stall    = stall1 || stall2 || md_stall;

  assign RD1_D_final = fwd(
    hit(D_A1, e_q.a3) && (e_q.tnew == '0),
    hit(D_A1, m_q.a3) && (m_q.tnew == '0),
    hit(D_A1, w_a3_q),
    Data_E, Data_M, Data_W, D_RD1);

  assign RD2_D_final = fwd(
    hit(D_A2, e_q.a3) && (e_q.tnew == '0),
    hit(D_A2, m_q.a3) && (m_q.tnew == '0),
    hit(D_A2, w_a3_q),
    Data_E, Data_M, Data_W, D_RD2);

  assign RD1_E_final = fwd(
    1'b0,
    e_u1_q && hit(e_a1_q, m_q.a3) && (m_q.tnew == '0),
    e_u1_q && hit(e_a1_q, w_a3_q),
    Data_E, Data_M, Data_W, E_RD1);

  assign RD2_E_final = fwd(
    1'b0,
    e_u2_q && hit(e_a2_q, m_q.a3) && (m_q.tnew == '0),
    e_u2_q && hit(e_a2_q, w_a3_q),
    Data_E, Data_M, Data_W, E_RD2);

  always_comb begin
    e_a1_d = '0;
    e_a2_d = '0;
    e_u1_d = 1'b0;
    e_u2_d = 1'b0;
    e_d    = BUBBLE;
    if (!stall) begin
      e_a1_d = D_A1;
      e_a2_d = D_A2;
      e_u1_d = (D_Tuse1 != TUSE_NONE);
      e_u2_d = (D_Tuse2 != TUSE_NONE);
      e_d    = '{a3: D_A3, tnew: D_Tnew};
    end
    m_d    = '{a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
    w_a3_d = m_q.a3;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q    <= BUBBLE;
      e_a1_q <= '0;
      e_a2_q <= '0;
      e_u1_q <= 1'b0;
      e_u2_q <= 1'b0;
      m_q    <= BUBBLE;
      w_a3_q <= '0;
    end else begin
      e_q    <= e_d;
      e_a1_q <= e_a1_d;
      e_a2_q <= e_a2_d;
      e_u1_q <= e_u1_d;
      e_u2_q <= e_u2_d;
      m_q    <= m_d;
      w_a3_q <= w_a3_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Vector-table bench for hazard_ctrl with an expected-result
// queue checked on the falling edge.
module tb_hazard_ctrl;

  localparam int N  = 3;
  localparam int D1 = 'hD1;
  localparam int D2 = 'hD2;
  localparam int E1 = 'hE1;
  localparam int E2 = 'hE2;
  localparam int XE = 'h11;
  localparam int XM = 'h22;
  localparam int XW = 'h33;

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] x1d;
    logic [31:0] x2d;
    logic [31:0] x1e;
    logic [31:0] x2e;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [4:0]  a1, a2, a3;
    logic [1:0]  t1, t2, tn;
    logic        md, st, dv;
    logic [31:0] rd1, dm;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_A1, D_A2, D_A3;
  logic [1:0]  D_Tuse1, D_Tuse2, D_Tnew;
  logic        D_MD, E_start, E_is_div;
  logic [31:0] D_RD1, D_RD2, E_RD1, E_RD2;
  logic [31:0] Data_E, Data_M, Data_W;
  logic        stall, md_busy;
  logic [31:0] RD1_D_final, RD2_D_final;
  logic [31:0] RD1_E_final, RD2_E_final;

  vec_t vq[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_A1        (D_A1),
    .D_A2        (D_A2),
    .D_Tuse1     (D_Tuse1),
    .D_Tuse2     (D_Tuse2),
    .D_A3        (D_A3),
    .D_Tnew      (D_Tnew),
    .D_MD        (D_MD),
    .D_RD1       (D_RD1),
    .D_RD2       (D_RD2),
    .E_RD1       (E_RD1),
    .E_RD2       (E_RD2),
    .E_start     (E_start),
    .E_is_div    (E_is_div),
    .Data_E      (Data_E),
    .Data_M      (Data_M),
    .Data_W      (Data_W),
    .stall       (stall),
    .md_busy     (md_busy),
    .RD1_D_final (RD1_D_final),
    .RD2_D_final (RD2_D_final),
    .RD1_E_final (RD1_E_final),
    .RD2_E_final (RD2_E_final)
  );

  task automatic row(
    input int r, a1, t1, a2, t2, a3, tn,
    input int md, st, dv, rd1, dm,
    input int s, b, x1d, x2d, x1e, x2e
  );
    vec_t v;
    v.rst = r[0];
    v.a1  = 5'(a1);
    v.t1  = 2'(t1);
    v.a2  = 5'(a2);
    v.t2  = 2'(t2);
    v.a3  = 5'(a3);
    v.tn  = 2'(tn);
    v.md  = md[0];
    v.st  = st[0];
    v.dv  = dv[0];
    v.rd1 = 32'(rd1);
    v.dm  = 32'(dm);
    v.e.s   = s[0];
    v.e.b   = b[0];
    v.e.x1d = 32'(x1d);
    v.e.x2d = 32'(x2d);
    v.e.x1e = 32'(x1e);
    v.e.x2e = 32'(x2e);
    vq.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    if (act !== want) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %h expected %h",
               n_vec, nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      chk("stall", 32'(stall), 32'(e.s));
      chk("md_busy", 32'(md_busy), 32'(e.b));
      chk("RD1_D", RD1_D_final, e.x1d);
      chk("RD2_D", RD2_D_final, e.x2d);
      chk("RD1_E", RD1_E_final, e.x1e);
      chk("RD2_E", RD2_E_final, e.x2e);
    end
  end

  initial begin
    reset    = 1'b0;
    D_A1     = '0;
    D_A2     = '0;
    D_A3     = '0;
    D_Tuse1  = 2'(N);
    D_Tuse2  = 2'(N);
    D_Tnew   = '0;
    D_MD     = 1'b0;
    E_start  = 1'b0;
    E_is_div = 1'b0;
    D_RD1    = 32'(D1);
    D_RD2    = 32'(D2);
    E_RD1    = 32'(E1);
    E_RD2    = 32'(E2);
    Data_E   = 32'(XE);
    Data_M   = 32'(XM);
    Data_W   = 32'(XW);

    // reset, then load-use on lw $8
    row(0, 0,N, 0,N, 0,0, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 0,N, 0,N, 0,0, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1,29,1, 0,N, 8,2, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 8,1,10,1, 9,1, 0,0,0, D1,XM, 1,0, D1,D2,E1,E2);
    row(1, 8,1,10,1, 9,1, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 0,N, 0,N, 0,0, 0,0,0, D1,XM, 0,0, D1,D2,XW,E2);
    // add $3 then beq $3
    row(1, 1,1, 2,1, 3,1, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 3,0, 0,0, 0,0, 0,0,0, D1,XM, 1,0, D1,D2,E1,E2);
    row(1, 3,0, 0,0, 0,0, 0,0,0, D1, 5, 0,0,  5,D2,E1,E2);
    // register 0
    row(1, 5,1, 0,N, 0,2, 0,0,0,  0,XM, 0,0,  0,D2,XW,E2);
    row(1, 0,0, 0,0, 6,1, 0,0,0,  0,XM, 0,0,  0,D2,E1,E2);
    // E over M priority
    row(1, 0,N, 0,N, 4,0, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 0,N, 0,N, 4,0, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 4,0, 6,0, 0,0, 0,0,0, D1,XM, 0,0, XE,XW,E1,E2);
    row(1, 0,N, 0,N, 0,0, 0,0,0, D1,XM, 0,0, D1,D2,XM,E2);
    // young E decides; M Tnew saturates at 0
    row(1, 0,N, 0,N, 7,3, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 0,N, 0,N, 7,0, 0,0,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 7,1, 0,N, 0,0, 0,0,0, D1,XM, 0,0, XE,D2,E1,E2);
    row(1, 7,0, 0,N, 0,0, 0,0,0, D1,XM, 0,0, XM,D2,XM,E2);
    row(1, 0,N, 0,N, 0,0, 0,0,0, D1,XM, 0,0, D1,D2,XW,E2);

    // divide with mfhi held in D
    for (int i = 1; i <= 12; i++)
      row(1, 0,N, 0,N, 0,0, 1, (i == 1), 1, D1,XM,
          (i <= 11), (i >= 2 && i <= 11), D1,D2,E1,E2);

    // reset while a multiply is counting
    row(1, 0,N, 0,N,12,3, 0,1,0, D1,XM, 0,0, D1,D2,E1,E2);
    row(1, 0,N, 0,N,13,3, 0,0,0, D1,XM, 0,1, D1,D2,E1,E2);
    row(1, 0,N, 0,N,14,3, 0,0,0, D1,XM, 0,1, D1,D2,E1,E2);
    row(0, 0,N, 0,N, 0,0, 1,0,0, D1,XM, 1,1, D1,D2,E1,E2);
    row(1,14,0,12,0, 0,0, 1,0,0, D1,XM, 0,0, D1,D2,E1,E2);

    // plain multiply with a HI/LO reader in D
    for (int i = 1; i <= 7; i++)
      row(1, 0,N, 0,N, 0,0, 1, (i == 1), 0, D1,XM,
          (i <= 6), (i >= 2 && i <= 6), D1,D2,E1,E2);

    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      reset    = vq[i].rst;
      D_A1     = vq[i].a1;
      D_Tuse1  = vq[i].t1;
      D_A2     = vq[i].a2;
      D_Tuse2  = vq[i].t2;
      D_A3     = vq[i].a3;
      D_Tnew   = vq[i].tn;
      D_MD     = vq[i].md;
      E_start  = vq[i].st;
      E_is_div = vq[i].dv;
      D_RD1    = vq[i].rd1;
      Data_M   = vq[i].dm;
      exp_q.push_back(vq[i].e);
    end

    for (int k = 0; k < 4 && exp_q.size() != 0; k++)
      @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
